// File: rtl/uart_tx_responder.sv
// Memory-mapped 8N1 UART transmitter: TX FIFO, baud-timed serialiser, STAT/DIV/CTRL registers.
// Define UART_TX_IRQ_EN to build the CTRL register and the level transmit-complete interrupt.
module uart_tx_responder #(
  parameter int CLK_HZ     = 27000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ren,
  input  logic        wen,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        irq
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [15:0]   DIV_RESET  = 16'(CLK_HZ / BAUD);
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic          tx_q, tx_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [15:0]   div_q, div_d;
  logic [15:0]   div_reg_q, div_reg_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    fifo_mem [FIFO_DEPTH];

  logic sel_data, sel_stat, sel_div;
  logic full, empty, busy, push_req, push_ok, pop, bit_end;
  logic unused_bits;

`ifdef UART_TX_IRQ_EN
  logic irq_en_q, irq_en_d, irq_q, irq_d;
`endif

  assign sel_data    = (addr[3:2] == 2'd0);
  assign sel_stat    = (addr[3:2] == 2'd1);
  assign sel_div     = (addr[3:2] == 2'd2);
  assign full        = (count_q == FULL_COUNT);
  assign empty       = (count_q == '0);
  assign busy        = (state_q != IDLE);
  assign pop         = (state_q == IDLE) && !empty;
  assign push_req    = wen && sel_data;
  assign push_ok     = push_req && (!full || pop);
  assign unused_bits = ^{wdata[31:16], addr[1:0]};
  assign tx          = tx_q;

  always_comb begin
    wr_ptr_d  = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d   = count_q;
    if (push_ok && !pop)      count_d = count_q + 1'b1;
    else if (!push_ok && pop) count_d = count_q - 1'b1;
    ovf_d = ovf_q;
    if (push_req && !push_ok)             ovf_d = 1'b1;
    else if (wen && sel_stat && wdata[3]) ovf_d = 1'b0;
    div_reg_d = div_reg_q;
    if (wen && sel_div) div_reg_d = (wdata[15:0] == 16'd0) ? 16'd1 : wdata[15:0];
  end

  // Each bit level lasts div_q clocks; div_q is captured once per frame so DIV writes wait a frame.
  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    bit_end   = (cnt_q == div_q - 16'd1);
    case (state_q)
      IDLE: if (!empty) begin
        state_d = START;
        tx_d    = 1'b0;
        shift_d = fifo_mem[rd_ptr_q];
        div_d   = div_reg_q;
        cnt_d   = '0;
      end
      START: if (bit_end) begin
        state_d   = DATA;
        tx_d      = shift_q[0];
        shift_d   = {1'b0, shift_q[7:1]};
        bit_cnt_d = '0;
        cnt_d     = '0;
      end else cnt_d = cnt_q + 16'd1;
      DATA: if (bit_end) begin
        cnt_d = '0;
        if (bit_cnt_q == 3'd7) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end else begin
          tx_d      = shift_q[0];
          shift_d   = {1'b0, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
      end else cnt_d = cnt_q + 16'd1;
      STOP: if (bit_end) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else cnt_d = cnt_q + 16'd1;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rdata = '0;
    if (ren) begin
      case (addr[3:2])
        2'd1: rdata = {28'd0, ovf_q, busy, empty, full};
        2'd2: rdata = {16'd0, div_reg_q};
`ifdef UART_TX_IRQ_EN
        2'd3: rdata = {31'd0, irq_en_q};
`endif
        default: rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      tx_q      <= 1'b1;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      cnt_q     <= '0;
      div_q     <= '0;
      div_reg_q <= DIV_RESET;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      div_reg_q <= div_reg_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
    end
  end

  // Storage needs no reset: pointers and count are cleared, so stale entries are unreachable.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr_q] <= wdata[7:0];
  end

`ifdef UART_TX_IRQ_EN
  always_comb begin
    irq_en_d = irq_en_q;
    if (wen && addr[3:2] == 2'd3) irq_en_d = wdata[0];
    irq_d = irq_en_q & empty & ~busy;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_responder.sv
// Scoreboard bench for uart_tx_responder: stimulus queues expected {div, byte} frames,
// a line monitor decodes tx against an ideal 8N1 waveform. Build with UART_TX_IRQ_EN to check irq.
module tb_uart_tx_responder;

  localparam logic [3:0] A_DATA = 4'h0;
  localparam logic [3:0] A_STAT = 4'h4;
  localparam logic [3:0] A_DIV  = 4'h8;
  localparam logic [3:0] A_CTRL = 4'hC;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        ren   = 1'b0;
  logic        wen   = 1'b0;
  logic [3:0]  addr  = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        tx, irq;

  uart_tx_responder #(.CLK_HZ(27000000), .BAUD(115200), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .ren(ren), .wen(wen), .addr(addr),
    .wdata(wdata), .rdata(rdata), .tx(tx), .irq(irq)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  int   exp_q[$];
  bit   in_frame = 1'b0;
  int   last_gap = 0;
  logic samp_tx, samp_irq;

  // Monitor-private state
  logic       m_prev = 1'b1;
  int         m_idle = 0;
  int         m_entry, m_div, m_mism, m_slot;
  logic [7:0] m_exp, m_got;
  logic       m_lvl;
  bit         m_abort;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // One-cycle bus write; all tasks start and end 1ns after a rising edge
  task automatic applyStimulus(input logic [3:0] a, input logic [31:0] d);
    addr = a; wdata = d; wen = 1'b1;
    @(posedge clk); #1;
    wen = 1'b0;
  endtask

  task automatic busRead(input logic [3:0] a, output logic [31:0] rd);
    addr = a; ren = 1'b1;
    @(negedge clk);
    rd = rdata; samp_tx = tx; samp_irq = irq;
    @(posedge clk); #1;
    ren = 1'b0;
  endtask

  task automatic pushByte(input logic [7:0] b, input int div);
    exp_q.push_back((div << 8) | int'(b));
    applyStimulus(A_DATA, {24'd0, b});
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || in_frame) && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    checkOutput("drain_timeout", 32'(n >= budget), 0);
    idleCycles(2);
  endtask

  task automatic measureBusy(output int n);
    logic [31:0] rd;
    bit seen = 1'b0;
    n = 0;
    for (int k = 0; k < 500; k++) begin
      busRead(A_STAT, rd);
      if (rd[2]) begin n++; seen = 1'b1; end
      else if (seen) break;
    end
  endtask

  // Line monitor: on each start edge, compare 10*div samples against the ideal frame
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_prev = 1'b1; m_idle = 0;
      end else if (m_prev && !tx) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_frame", 1, 0);
          m_prev = tx;
        end else begin
          in_frame = 1'b1;
          m_entry  = exp_q.pop_front();
          m_div    = m_entry >> 8;
          m_exp    = m_entry[7:0];
          last_gap = m_idle;
          m_mism = 0; m_got = '0; m_abort = 1'b0;
          for (int i = 0; i < 10 * m_div; i++) begin
            if (i > 0) @(negedge clk);
            if (!rst_n) begin m_abort = 1'b1; break; end
            m_slot = i / m_div;
            m_lvl  = (m_slot == 0) ? 1'b0 : (m_slot == 9) ? 1'b1 : m_exp[m_slot-1];
            if (tx !== m_lvl) m_mism++;
            if (m_slot >= 1 && m_slot <= 8 && (i % m_div) == m_div / 2) m_got[m_slot-1] = tx;
          end
          if (!m_abort) begin
            checkOutput("frame_byte", m_got, m_exp);
            checkOutput("frame_shape_errors", m_mism, 0);
          end
          m_idle = 0; m_prev = 1'b1; in_frame = 1'b0;
        end
      end else begin
        m_idle = tx ? m_idle + 1 : 0;
        m_prev = tx;
      end
    end
  end

  initial begin : watchdog
    #800000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    logic [31:0] rd;
    int          n, lows, blen, div;
    logic [7:0]  b;
    bit          found;

    // Reset state
    repeat (3) @(posedge clk); #1;
    checkOutput("reset_tx", tx, 1);
    checkOutput("reset_irq", irq, 0);
    ren = 1'b1;
    addr = A_STAT; #1; checkOutput("reset_stat", rdata, 32'h2);
    addr = A_DIV;  #1; checkOutput("reset_div", rdata, 234);
    addr = A_CTRL; #1; checkOutput("reset_ctrl", rdata, 0);
    ren = 1'b0;
    rst_n = 1'b1;
    idleCycles(2);

    // 0x55 at DIV=4: latency, busy span and waveform
    applyStimulus(A_DIV, 4);
    busRead(A_DIV, rd); checkOutput("div_readback", rd, 4);
    busRead(A_DATA, rd); checkOutput("data_reads_zero", rd, 0);
    pushByte(8'h55, 4);
    busRead(A_STAT, rd);
    checkOutput("stat_after_push", rd, 32'h0);
    checkOutput("tx_high_n1", samp_tx, 1);
    busRead(A_STAT, rd);
    checkOutput("stat_frame_start", rd, 32'h6);
    checkOutput("tx_low_n2", samp_tx, 0);
    n = 1;
    for (int k = 0; k < 200; k++) begin
      busRead(A_STAT, rd);
      if (rd[2]) n++; else break;
    end
    checkOutput("busy_cycles_div4", n, 40);
    waitDrain(2000);

    // Back-to-back frames
    pushByte(8'hA3, 4);
    pushByte(8'h0F, 4);
    waitDrain(2000);
    checkOutput("b2b_idle_gap", last_gap, 1);

    // DIV=0 stores 1; mid-frame DIV write waits for the next frame
    applyStimulus(A_DIV, 0);
    busRead(A_DIV, rd); checkOutput("div_zero_stores_one", rd, 1);
    pushByte(8'hFF, 1);
    measureBusy(n);
    checkOutput("busy_cycles_div1", n, 10);
    waitDrain(2000);
    pushByte(8'h00, 1);
    idleCycles(2);
    applyStimulus(A_DIV, 5);
    waitDrain(2000);
    busRead(A_DIV, rd); checkOutput("div_after_midframe_write", rd, 5);
    pushByte(8'h5A, 5);
    waitDrain(2000);

    // Randomised bursts
    for (int r = 0; r < 6; r++) begin
      div = $urandom_range(1, 6);
      applyStimulus(A_DIV, div);
      blen = $urandom_range(1, 4);
      for (int j = 0; j < blen; j++) begin
        b = 8'($urandom);
        pushByte(b, div);
        idleCycles($urandom_range(0, 3));
      end
      waitDrain(5000);
      busRead(A_STAT, rd); checkOutput("stat_after_burst", rd, 32'h2);
    end

    // Interrupt
    applyStimulus(A_DIV, 4);
`ifdef UART_TX_IRQ_EN
    applyStimulus(A_CTRL, 1);
    busRead(A_CTRL, rd); checkOutput("ctrl_readback", rd, 1);
    idleCycles(2);
    busRead(A_STAT, rd); checkOutput("irq_idle_high", samp_irq, 1);
    pushByte(8'h41, 4);
    idleCycles(1);
    busRead(A_STAT, rd); checkOutput("irq_low_after_push", samp_irq, 0);
    found = 1'b0;
    for (int k = 0; k < 200; k++) begin
      busRead(A_STAT, rd);
      if (!rd[2]) begin found = 1'b1; break; end
    end
    checkOutput("stop_end_seen", found, 1);
    checkOutput("irq_at_stop_end", samp_irq, 0);
    busRead(A_STAT, rd); checkOutput("irq_rise", samp_irq, 1);
    pushByte(8'h42, 4);
    busRead(A_STAT, rd);
    busRead(A_STAT, rd); checkOutput("irq_clear_on_push", samp_irq, 0);
    waitDrain(2000);
    busRead(A_STAT, rd); checkOutput("irq_high_again", samp_irq, 1);
    applyStimulus(A_CTRL, 0);
    idleCycles(1);
    busRead(A_STAT, rd); checkOutput("irq_clear_on_disable", samp_irq, 0);
`else
    applyStimulus(A_CTRL, 1);
    busRead(A_CTRL, rd); checkOutput("ctrl_reads_zero", rd, 0);
    pushByte(8'h41, 4);
    waitDrain(2000);
    busRead(A_STAT, rd); checkOutput("irq_tied_low", samp_irq, 0);
`endif

    // Overflow with a frame in progress, then reset mid-frame
    applyStimulus(A_DIV, 234);
    pushByte(8'h11, 234);
    idleCycles(3);
    for (int j = 0; j < 8; j++) pushByte(8'(8'h20 + j), 234);
    applyStimulus(A_DATA, 32'h99);
    busRead(A_STAT, rd); checkOutput("stat_full_ovf", rd, 32'hD);
    applyStimulus(A_STAT, 32'h8);
    busRead(A_STAT, rd); checkOutput("stat_ovf_cleared", rd, 32'h5);
    idleCycles(300);
    rst_n = 1'b0; #1;
    checkOutput("midframe_reset_tx", tx, 1);
    ren = 1'b1;
    addr = A_STAT; #1; checkOutput("midframe_reset_stat", rdata, 32'h2);
    addr = A_DIV;  #1; checkOutput("midframe_reset_div", rdata, 234);
    ren = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    lows = 0;
    repeat (3000) begin
      @(negedge clk);
      if (!tx) lows++;
    end
    checkOutput("no_frame_after_reset", lows, 0);
    #1;
    busRead(A_STAT, rd); checkOutput("stat_after_reset", rd, 32'h2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
